lcd_write_arbiter: RTL and testbench
====================================

// Module: lcd_write_arbiter
// PURPOSE
//  Shares the single LCD control master between two write requesters (0: CPU display port,
//  1: status/debug writer). Round-robin arbitration, latches the winner's transfer
//  descriptor, issues a one-cycle lcdWrite while the master reports lcdReady, then tracks
//  the master through busy and back to ready. Watchdog aborts a transfer that never completes.
// PARAMETERS
//  TIMEOUT  4095  cycles allowed in WAIT_BUSY+WAIT_DONE before abort (>=1)
//  TO_W     12    timeout counter width; TIMEOUT must fit in TO_W bits
// PORTS
//  CLK            in   1  clock, all state on rising edge
//  RESET          in   1  reset, asynchronous, active-high
//  req0/req1      in   1  level request; held high until matching doneN pulse
//  start0/start1  in   4  LCD column start address of requester's transfer
//  count0/count1  in   4  byte count of requester's transfer (passed through unchanged)
//  row0/row1      in   1  LCD row of requester's transfer
//  done0/done1    out  1  one-cycle pulse: granted transfer finished or aborted
//  grantId        out  1  requester currently owning the master (selects its byte buffer)
//  busy           out  1  1 in every state except IDLE
//  lcdReady       in   1  master idle and able to accept lcdWrite
//  lcdWrite       out  1  write strobe to master, one cycle
//  lcdStartAddr   out  4  latched start address to master
//  lcdCount       out  4  latched count to master
//  lcdRow         out  1  latched row to master
//  timeoutErr     out  1  sticky watchdog flag
//  errClr         in   1  synchronous clear of timeoutErr
// BEHAVIOUR
//  Reset: state=IDLE, lastGrant=1, grantId=0, lcdWrite=0, done0=done1=0, busy=0,
//   lcdStartAddr=0, lcdCount=0, lcdRow=0, toCnt=0, timeoutErr=0. All outputs registered.
//  States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.
//  IDLE: if lcdReady & (req0|req1): pick winner, latch startN/countN/rowN to lcd* outputs,
//   grantId<=winner, lastGrant<=winner, -> ISSUE. Otherwise stay; no request -> stay.
//  Arbitration: one req -> that one; both -> requester != lastGrant (req0 wins first tie).
//  ISSUE: lcdWrite=1 for exactly this cycle; -> WAIT_BUSY unconditionally; toCnt<=0.
//  WAIT_BUSY: lcdReady==0 -> WAIT_DONE; else stay, toCnt++.
//  WAIT_DONE: lcdReady==1 -> DONE; else stay, toCnt++.
//  Watchdog: in WAIT_BUSY/WAIT_DONE, toCnt==TIMEOUT-1 on an edge -> timeoutErr<=1, -> DONE
//   (abort). Counter saturates, never wraps.
//  DONE: done<grantId>=1 for this cycle only; -> IDLE. Earliest re-grant is the IDLE cycle
//   after DONE, so a requester must drop req the cycle after its done pulse.
//  Latency: req with lcdReady high in cycle t -> lcdWrite in t+1 -> WAIT_BUSY in t+2;
//   done pulse one cycle after the first lcdReady=1 seen in WAIT_DONE.
//  lcd* descriptor and grantId are stable from ISSUE through DONE; input changes on
//   startN/countN/rowN after grant are ignored. req dropped mid-transfer does not abort.
//  Master re-init (lcdReady low then high) while granted completes the transfer normally;
//   data loss is not detected here.
//  errClr and timeout abort on same edge: timeoutErr set wins. errClr alone clears it.
//  RESET mid-transfer: immediate return to reset values, no done pulse issued.
// TESTING
//  1 req0=1,start0=3,count0=5,row0=1, ready model: lcdWrite at t+1, lcdStartAddr=3,
//    lcdCount=5, lcdRow=1; model busy 20 cycles -> done0 one cycle, done1 never.
//  2 req0=req1=1 held continuously after reset -> grants alternate 0,1,0,1; each done once.
//  3 lcdReady=0 at request -> no lcdWrite until lcdReady=1; then grant as scenario 1.
//  4 TIMEOUT=8, model never drops lcdReady -> abort after 8 cycles, done pulse,
//    timeoutErr=1 until errClr pulse, then 0.
//  5 RESET asserted in WAIT_DONE -> outputs at reset values same cycle, no done;
//    after release req1 alone granted first.
//  6 change start0 to 9 during WAIT_DONE -> lcdStartAddr holds the latched value.

Source files
------------

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one LCD control master between two write requesters.
// Latches the winner's descriptor, strobes lcdWrite, tracks the master busy/ready cycle, aborts on watchdog.
module lcd_write_arbiter #(
    parameter int TIMEOUT = 4095,
    parameter int TO_W    = 12
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] start0,
    input  logic [3:0] start1,
    input  logic [3:0] count0,
    input  logic [3:0] count1,
    input  logic       row0,
    input  logic       row1,
    output logic       done0,
    output logic       done1,
    output logic       grantId,
    output logic       busy,
    input  logic       lcdReady,
    output logic       lcdWrite,
    output logic [3:0] lcdStartAddr,
    output logic [3:0] lcdCount,
    output logic       lcdRow,
    output logic       timeoutErr,
    input  logic       errClr,
    output logic [2:0] state_dbg
);

    // Handshake: a requester raises reqN and holds it (with a stable descriptor) until
    // the grant is taken; doneN pulses once when that transfer ends or is aborted.
    // The master accepts lcdWrite only while lcdReady is high, then drops lcdReady while
    // busy and raises it again when finished.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            grant_q, grant_d;
    logic            lcd_write_q, lcd_write_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic            busy_q, busy_d;
    logic [3:0]      start_addr_q, start_addr_d;
    logic [3:0]      count_q, count_d;
    logic            row_q, row_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_err_q, timeout_err_d;
    logic            winner;
    logic            finish;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        lcd_write_d   = 1'b0;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        start_addr_d  = start_addr_q;
        count_d       = count_q;
        row_d         = row_q;
        to_cnt_d      = to_cnt_q;
        timeout_err_d = errClr ? 1'b0 : timeout_err_q;
        winner        = 1'b0;
        finish        = 1'b0;

        case (state_q)
            IDLE: begin
                if (lcdReady && (req0 || req1)) begin
                    // On a tie the requester that did not win last time goes next.
                    winner       = (req0 && req1) ? ~last_grant_q : req1;
                    grant_d      = winner;
                    last_grant_d = winner;
                    start_addr_d = winner ? start1 : start0;
                    count_d      = winner ? count1 : count0;
                    row_d        = winner ? row1   : row0;
                    lcd_write_d  = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                to_cnt_d = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY, WAIT_DONE: begin
                if (to_cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    finish        = 1'b1;
                end else if ((state_q == WAIT_BUSY) && !lcdReady) begin
                    state_d = WAIT_DONE;
                end else if ((state_q == WAIT_DONE) && lcdReady) begin
                    finish = 1'b1;
                end else if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
                if (finish) begin
                    state_d = DONE;
                    done0_d = ~grant_q;
                    done1_d = grant_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            grant_q       <= 1'b0;
            lcd_write_q   <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            busy_q        <= 1'b0;
            start_addr_q  <= 4'd0;
            count_q       <= 4'd0;
            row_q         <= 1'b0;
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            lcd_write_q   <= lcd_write_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            busy_q        <= busy_d;
            start_addr_q  <= start_addr_d;
            count_q       <= count_d;
            row_q         <= row_d;
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign done0        = done0_q;
    assign done1        = done1_q;
    assign grantId      = grant_q;
    assign busy         = busy_q;
    assign lcdWrite     = lcd_write_q;
    assign lcdStartAddr = start_addr_q;
    assign lcdCount     = count_q;
    assign lcdRow       = row_q;
    assign timeoutErr   = timeout_err_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: directed scenarios plus randomized transfers against a
// round-robin / timing model derived from the arbiter's documented behaviour.
module tb_lcd_write_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       req0, req1, row0, row1, lcdReady, errClr;
  logic [3:0] start0, start1, count0, count1;

  logic       done0, done1, grantId, busy, lcdWrite, lcdRow, timeoutErr;
  logic [3:0] lcdStartAddr, lcdCount;
  logic [2:0] state_dbg;

  logic       to_done0, to_done1, to_grantId, to_busy, to_lcdWrite, to_lcdRow, to_timeoutErr;
  logic [3:0] to_lcdStartAddr, to_lcdCount;
  logic [2:0] to_state_dbg;

  int         n_checks = 0;
  int         n_fail = 0;
  bit         last_grant_m;
  logic [9:0] exp_q[$];

  lcd_write_arbiter #(.TIMEOUT(64), .TO_W(7)) dut (
    .CLK(CLK), .RESET(RESET), .req0(req0), .req1(req1),
    .start0(start0), .start1(start1), .count0(count0), .count1(count1),
    .row0(row0), .row1(row1), .done0(done0), .done1(done1),
    .grantId(grantId), .busy(busy), .lcdReady(lcdReady), .lcdWrite(lcdWrite),
    .lcdStartAddr(lcdStartAddr), .lcdCount(lcdCount), .lcdRow(lcdRow),
    .timeoutErr(timeoutErr), .errClr(errClr), .state_dbg(state_dbg)
  );

  lcd_write_arbiter #(.TIMEOUT(8), .TO_W(4)) dut_to (
    .CLK(CLK), .RESET(RESET), .req0(req0), .req1(req1),
    .start0(start0), .start1(start1), .count0(count0), .count1(count1),
    .row0(row0), .row1(row1), .done0(to_done0), .done1(to_done1),
    .grantId(to_grantId), .busy(to_busy), .lcdReady(lcdReady), .lcdWrite(to_lcdWrite),
    .lcdStartAddr(to_lcdStartAddr), .lcdCount(to_lcdCount), .lcdRow(to_lcdRow),
    .timeoutErr(to_timeoutErr), .errClr(errClr), .state_dbg(to_state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not finish, got running required finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    req0 = 0; req1 = 0; row0 = 0; row1 = 0; errClr = 0; lcdReady = 1'b1;
    start0 = 0; start1 = 0; count0 = 0; count1 = 0;
    repeat (2) step();
    RESET = 1'b0;
    last_grant_m = 1'b1;
    exp_q.delete();
  endtask

  task automatic randomize_desc();
    start0 = 4'($urandom_range(0, 15)); start1 = 4'($urandom_range(0, 15));
    count0 = 4'($urandom_range(0, 15)); count1 = 4'($urandom_range(0, 15));
    row0 = 1'($urandom_range(0, 1));    row1 = 1'($urandom_range(0, 1));
  endtask

  // driver + master model for one transfer on the main instance
  task automatic run_xfer(input bit r0, input bit r1, input bit hold, input int pre_wait,
                          input int busy_dly, input int done_dly, input string tag);
    bit         w;
    logic [9:0] exp;
    logic [9:0] got;
    if (pre_wait > 0) begin
      lcdReady = 1'b0; req0 = r0; req1 = r1;
      repeat (pre_wait) begin
        step();
        n_checks++;
        if ({lcdWrite, busy} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s no_grant_when_not_ready: got write,busy=%b required 00", tag, {lcdWrite, busy});
        end
      end
    end
    req0 = r0; req1 = r1; lcdReady = 1'b1;
    w = (r0 && r1) ? !last_grant_m : r1;
    last_grant_m = w;
    exp = w ? {1'b1, row1, count1, start1} : {1'b0, row0, count0, start0};
    exp_q.push_back(exp);
    step();
    got = {grantId, lcdRow, lcdCount, lcdStartAddr};
    n_checks++;
    if ({lcdWrite, busy} !== 2'b11 || got !== exp) begin
      n_fail++;
      $display("FAIL %s grant: got write,busy=%b desc=%h required 11 desc=%h", tag, {lcdWrite, busy}, got, exp);
    end
    step();
    n_checks++;
    if ({lcdWrite, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s write_one_cycle: got write,busy=%b required 01", tag, {lcdWrite, busy});
    end
    start0 = 4'd9; start1 = 4'($urandom_range(0, 15));
    count0 = 4'($urandom_range(0, 15)); count1 = 4'($urandom_range(0, 15));
    row0 = ~row0; row1 = ~row1;
    repeat (busy_dly) begin
      step();
      n_checks++;
      if ({done0, done1} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s early_done_busy: got done=%b required 00", tag, {done1, done0});
      end
    end
    lcdReady = 1'b0;
    repeat (done_dly) begin
      step();
      n_checks++;
      if ({done0, done1} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s early_done_wait: got done=%b required 00", tag, {done1, done0});
      end
    end
    lcdReady = 1'b1;
    step();
    exp = exp_q.pop_front();
    got = {grantId, lcdRow, lcdCount, lcdStartAddr};
    n_checks++;
    if ({done1, done0} !== (exp[9] ? 2'b10 : 2'b01) || got !== exp || timeoutErr !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done: got done=%b desc=%h err=%b required done=%b desc=%h err=0",
               tag, {done1, done0}, got, timeoutErr, (exp[9] ? 2'b10 : 2'b01), exp);
    end
    if (!hold) begin
      req0 = 1'b0; req1 = 1'b0;
    end
    step();
    n_checks++;
    if ({done0, done1, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s back_to_idle: got done1,done0,busy=%b required 000", tag, {done1, done0, busy});
    end
    for (int i = 0; i < 100 && busy !== 1'b0; i++) step();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({done0, done1, grantId, busy, lcdWrite, lcdStartAddr, lcdCount, lcdRow, timeoutErr, state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got %b required all zero",
               {done0, done1, grantId, busy, lcdWrite, lcdStartAddr, lcdCount, lcdRow, timeoutErr, state_dbg});
    end
    n_checks++;
    if ({to_done0, to_done1, to_busy, to_lcdWrite, to_timeoutErr, to_state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL reset_values_wd: got %b required all zero",
               {to_done0, to_done1, to_busy, to_lcdWrite, to_timeoutErr, to_state_dbg});
    end
    repeat (3) step();
    n_checks++;
    if ({busy, lcdWrite} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_no_request: got busy,write=%b required 00", {busy, lcdWrite});
    end
  endtask

  task automatic test_single();
    apply_reset();
    randomize_desc();
    start0 = 4'd3; count0 = 4'd5; row0 = 1'b1;
    run_xfer(1'b1, 1'b0, 1'b0, 0, 0, 20, "single");
  endtask

  task automatic test_not_ready();
    apply_reset();
    randomize_desc();
    start0 = 4'd3; count0 = 4'd5; row0 = 1'b1;
    run_xfer(1'b1, 1'b0, 1'b0, 4, 1, 5, "not_ready");
  endtask

  task automatic test_round_robin();
    apply_reset();
    randomize_desc();
    for (int i = 0; i < 4; i++)
      run_xfer(1'b1, 1'b1, 1'b1, 0, $urandom_range(0, 3), $urandom_range(1, 6), "round_robin");
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_watchdog();
    apply_reset();
    req1 = 1'b1; start1 = 4'd7; lcdReady = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k < 10) begin
        n_checks++;
        if ({to_done0, to_done1, to_timeoutErr} !== 3'b000) begin
          n_fail++;
          $display("FAIL wd_before_abort cycle %0d: got done0,done1,err=%b required 000", k, {to_done0, to_done1, to_timeoutErr});
        end
      end
    end
    n_checks++;
    if ({to_done0, to_done1, to_timeoutErr, to_lcdStartAddr} !== {3'b011, 4'd7}) begin
      n_fail++;
      $display("FAIL wd_abort: got done0,done1,err=%b addr=%0d required 011 addr=7",
               {to_done0, to_done1, to_timeoutErr}, to_lcdStartAddr);
    end
    req1 = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({to_timeoutErr, to_busy, to_done1} !== 3'b100) begin
      n_fail++;
      $display("FAIL wd_sticky: got err,busy,done1=%b required 100", {to_timeoutErr, to_busy, to_done1});
    end
    errClr = 1'b1;
    step();
    errClr = 1'b0;
    n_checks++;
    if (to_timeoutErr !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_errclr: got err=%b required 0", to_timeoutErr);
    end
    req0 = 1'b1;
    for (int k = 1; k <= 9; k++) step();
    errClr = 1'b1;
    step();
    n_checks++;
    if ({to_done0, to_timeoutErr} !== 2'b11) begin
      n_fail++;
      $display("FAIL wd_set_beats_clear: got done0,err=%b required 11", {to_done0, to_timeoutErr});
    end
    req0 = 1'b0;
    step();
    errClr = 1'b0;
    n_checks++;
    if (to_timeoutErr !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_clear_after: got err=%b required 0", to_timeoutErr);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    randomize_desc();
    req0 = 1'b1; lcdReady = 1'b1;
    step();
    step();
    lcdReady = 1'b0;
    repeat (3) step();
    #2;
    RESET = 1'b1;
    #1;
    n_checks++;
    if ({done0, done1, grantId, busy, lcdWrite, lcdStartAddr, lcdCount, lcdRow, timeoutErr} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b required all zero",
               {done0, done1, grantId, busy, lcdWrite, lcdStartAddr, lcdCount, lcdRow, timeoutErr});
    end
    lcdReady = 1'b1;
    step();
    RESET = 1'b0;
    req0 = 1'b0;
    last_grant_m = 1'b1;
    exp_q.delete();
    step();
    n_checks++;
    if ({done0, done1, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got done0,done1,busy=%b required 000", {done0, done1, busy});
    end
    randomize_desc();
    run_xfer(1'b0, 1'b1, 1'b0, 0, 1, 3, "after_reset");
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(1, 3);
      randomize_desc();
      run_xfer(r[0], r[1], 1'b0, $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(1, 12), "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_not_ready();
    test_round_robin();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
